// File: rtl/uart_rx_word_ctrl.sv
// UART RX word controller: pairs bytes (low first) into 16-bit words,
// valid/ready output, sel = state code, timeout/frame/overrun pulses.
//   in : clk, rst, rx_valid, rx_data[7:0], rx_frame_err, word_ready
//   out: word_valid, word_data[15:0], sel[2:0], timeout_err,
//        frame_err, overrun_err, word_count[CNT_W-1:0]
module uart_rx_word_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             rx_frame_err,
  input  logic             word_ready,
  output logic             word_valid,
  output logic [15:0]      word_data,
  output logic [2:0]       sel,
  output logic             timeout_err,
  output logic             frame_err,
  output logic             overrun_err,
  output logic [CNT_W-1:0] word_count
);

  localparam logic [2:0] S_IDLE    = 3'b000;
  localparam logic [2:0] S_WAIT_HI = 3'b001;
  localparam logic [2:0] S_HOLD    = 3'b010;

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  // Timer holds idle cycles seen minus one, so the idle cycle that
  // brings the gap to TIMEOUT_CYCLES-1 sees this value.
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 2);

  logic [2:0]    state;
  logic [7:0]    low_q;
  logic [TW-1:0] timer;
  logic          good_byte;
  logic          bad_byte;
  logic          handshake;

  assign good_byte = rx_valid & ~rx_frame_err;
  assign bad_byte  = rx_valid &  rx_frame_err;
  assign handshake = (state == S_HOLD) & word_ready;
  assign sel       = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      low_q       <= 8'h00;
      timer       <= '0;
      word_valid  <= 1'b0;
      word_data   <= 16'h0000;
      timeout_err <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      word_count  <= '0;
    end else begin
      timeout_err <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (good_byte) begin
            low_q <= rx_data;
            timer <= '0;
            state <= S_WAIT_HI;
          end else if (bad_byte) begin
            frame_err <= 1'b1;
          end
        end
        S_WAIT_HI: begin
          // An arriving byte takes priority over the timeout.
          if (good_byte) begin
            word_data  <= {rx_data, low_q};
            word_valid <= 1'b1;
            state      <= S_HOLD;
          end else if (bad_byte) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
          end else if (timer == T_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_HOLD: begin
          if (handshake) begin
            word_count <= word_count + CNT_W'(1);
            word_valid <= 1'b0;
            // A good byte in the handshake cycle starts the next word.
            if (good_byte) begin
              low_q <= rx_data;
              timer <= '0;
              state <= S_WAIT_HI;
            end else begin
              frame_err <= bad_byte;
              state     <= S_IDLE;
            end
          end else if (rx_valid) begin
            overrun_err <= 1'b1;
            frame_err   <= rx_frame_err;
          end
        end
        default: begin
          word_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_word_ctrl.sv
// Self-checking bench for uart_rx_word_ctrl: directed table, corner
// sequences, then random traffic against a behavioural model.
module tb_uart_rx_word_ctrl;

  localparam int TO = 1000;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_frame_err;
  logic          word_ready;
  logic          word_valid;
  logic [15:0]   word_data;
  logic [2:0]    sel;
  logic          timeout_err;
  logic          frame_err;
  logic          overrun_err;
  logic [CW-1:0] word_count;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_word_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_frame_err(rx_frame_err), .word_ready(word_ready),
    .word_valid(word_valid), .word_data(word_data), .sel(sel),
    .timeout_err(timeout_err), .frame_err(frame_err),
    .overrun_err(overrun_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: "have a pending word", "have a low byte",
  // count of idle cycles since the low byte, words delivered.
  bit       m_pend, m_part;
  bit [7:0] m_low;
  bit [15:0] m_word;
  int       m_gap, m_cnt;
  bit       m_te, m_fe, m_oe;

  function automatic void model_reset();
    m_pend = 0; m_part = 0; m_low = 0; m_word = 0;
    m_gap = 0; m_cnt = 0; m_te = 0; m_fe = 0; m_oe = 0;
  endfunction

  function automatic void model_step(bit v, bit [7:0] d, bit fe, bit rdy);
    bit good, bad;
    good = v && !fe;
    bad  = v && fe;
    m_te = 0; m_fe = 0; m_oe = 0;
    if (m_pend) begin
      if (rdy) begin
        m_cnt++;
        m_pend = 0;
        if (good) begin
          m_part = 1; m_low = d; m_gap = 0;
        end else if (bad) m_fe = 1;
      end else if (v) begin
        m_oe = 1; m_fe = fe;
      end
    end else if (m_part) begin
      if (good) begin
        m_word = {d, m_low}; m_pend = 1; m_part = 0;
      end else if (bad) begin
        m_fe = 1; m_part = 0;
      end else begin
        m_gap++;
        if (m_gap == TO - 1) begin
          m_te = 1; m_part = 0;
        end
      end
    end else if (good) begin
      m_part = 1; m_low = d; m_gap = 0;
    end else if (bad) m_fe = 1;
  endfunction

  function automatic logic [26:0] dut_vec();
    return {sel, word_valid, word_data, timeout_err, frame_err,
            overrun_err, word_count};
  endfunction

  function automatic logic [26:0] model_vec();
    logic [2:0] s;
    s = m_pend ? 3'b010 : (m_part ? 3'b001 : 3'b000);
    return {s, logic'(m_pend), m_word, logic'(m_te), logic'(m_fe),
            logic'(m_oe), CW'(m_cnt % (1 << CW))};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(bit v, bit [7:0] d, bit fe, bit rdy);
    rx_valid = v; rx_data = d; rx_frame_err = fe; word_ready = rdy;
    @(posedge clk);
    model_step(v, d, fe, rdy);
    #1;
    chk("model", 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b1; rx_data = 8'h5A; rx_frame_err = 1'b0;
    word_ready = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    chk("reset", 32'(dut_vec()), 32'd0);
    rst = 1'b0;
  endtask

  typedef struct {
    bit       v;
    bit [7:0] d;
    bit       fe;
    bit       rdy;
    bit [2:0] sel;
    bit       val;
    bit [15:0] data;
    bit       te, fe_o, oe;
    bit [3:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit v, bit [7:0] d, bit fe, bit rdy,
      bit [2:0] s, bit val, bit [15:0] data, bit te, bit fo, bit oe,
      bit [3:0] cnt);
    vec_t r;
    r.v = v; r.d = d; r.fe = fe; r.rdy = rdy; r.sel = s; r.val = val;
    r.data = data; r.te = te; r.fe_o = fo; r.oe = oe; r.cnt = cnt;
    tbl.push_back(r);
  endfunction

  initial begin
    // pair 34,12 with ready
    add(1, 8'h34, 0, 1, 3'd1, 0, 16'h0000, 0, 0, 0, 4'd0);
    add(1, 8'h12, 0, 1, 3'd2, 1, 16'h1234, 0, 0, 0, 4'd0);
    add(0, 8'h00, 0, 1, 3'd0, 0, 16'h1234, 0, 0, 0, 4'd1);
    // BEEF held, two overruns, then accept
    add(1, 8'hEF, 0, 0, 3'd1, 0, 16'h1234, 0, 0, 0, 4'd1);
    add(1, 8'hBE, 0, 0, 3'd2, 1, 16'hBEEF, 0, 0, 0, 4'd1);
    add(1, 8'h11, 0, 0, 3'd2, 1, 16'hBEEF, 0, 0, 1, 4'd1);
    add(1, 8'h22, 0, 0, 3'd2, 1, 16'hBEEF, 0, 0, 1, 4'd1);
    add(0, 8'h00, 0, 1, 3'd0, 0, 16'hBEEF, 0, 0, 0, 4'd2);
    // byte in the handshake cycle starts next word
    add(1, 8'h99, 0, 1, 3'd1, 0, 16'hBEEF, 0, 0, 0, 4'd2);
    add(1, 8'h88, 0, 1, 3'd2, 1, 16'h8899, 0, 0, 0, 4'd2);
    add(1, 8'h55, 0, 1, 3'd1, 0, 16'h8899, 0, 0, 0, 4'd3);
    add(1, 8'h66, 0, 1, 3'd2, 1, 16'h6655, 0, 0, 0, 4'd3);
    add(0, 8'h00, 0, 1, 3'd0, 0, 16'h6655, 0, 0, 0, 4'd4);
    // framing error on high byte
    add(1, 8'h10, 0, 1, 3'd1, 0, 16'h6655, 0, 0, 0, 4'd4);
    add(1, 8'h77, 1, 1, 3'd0, 0, 16'h6655, 0, 1, 0, 4'd4);
    add(0, 8'h00, 0, 1, 3'd0, 0, 16'h6655, 0, 0, 0, 4'd4);
    // bad byte in HOLD: without ready, then with ready
    add(1, 8'h01, 0, 0, 3'd1, 0, 16'h6655, 0, 0, 0, 4'd4);
    add(1, 8'h02, 0, 0, 3'd2, 1, 16'h0201, 0, 0, 0, 4'd4);
    add(1, 8'h03, 1, 0, 3'd2, 1, 16'h0201, 0, 1, 1, 4'd4);
    add(1, 8'h04, 1, 1, 3'd0, 0, 16'h0201, 0, 1, 0, 4'd5);
    // bad byte in IDLE
    add(1, 8'h05, 1, 1, 3'd0, 0, 16'h0201, 0, 1, 0, 4'd5);

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].fe, tbl[i].rdy);
      chk($sformatf("tbl%0d", i), 32'(dut_vec()),
          32'({tbl[i].sel, tbl[i].val, tbl[i].data, tbl[i].te,
               tbl[i].fe_o, tbl[i].oe, tbl[i].cnt}));
    end

    // timeout: 998 idle cycles survive, the 999th times out
    step(1, 8'hAA, 0, 1);
    for (int i = 0; i < TO - 2; i++) step(0, 8'h00, 0, 1);
    chk("to_pre_sel", 32'(sel), 32'd1);
    step(0, 8'h00, 0, 1);
    chk("to_pulse", 32'({timeout_err, sel}), 32'({1'b1, 3'd0}));
    step(0, 8'h00, 0, 1);
    chk("to_once", 32'(timeout_err), 32'd0);
    step(1, 8'h01, 0, 1);
    step(1, 8'h02, 0, 1);
    chk("to_next", 32'({word_valid, word_data}), 32'({1'b1, 16'h0201}));
    step(0, 8'h00, 0, 1);

    // byte on the last allowed cycle wins over timeout
    step(1, 8'hAA, 0, 0);
    for (int i = 0; i < TO - 2; i++) step(0, 8'h00, 0, 0);
    step(1, 8'hBB, 0, 0);
    chk("to_edge", 32'({timeout_err, word_valid, word_data}),
        32'({1'b0, 1'b1, 16'hBBAA}));
    step(0, 8'h00, 0, 1);

    // reset in the middle of WAIT_HI
    step(1, 8'h10, 0, 1);
    do_reset();

    // counter wrap: 17 back-to-back words with ready high
    for (int w = 0; w < 17; w++) begin
      step(1, 8'(w), 0, 1);
      step(1, 8'(w + 8'h40), 0, 1);
    end
    step(0, 8'h00, 0, 1);
    chk("wrap", 32'(word_count), 32'h1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      bit v, fe, rdy;
      v   = ($urandom_range(0, 99) < 55);
      fe  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 99) < 60);
      step(v, 8'($urandom), fe, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
